// File: rtl/ramb4_fifo_pkg.sv
// Shared sizing and arbitration types for the RAMB4_S1 streaming FIFO controller.
package ramb4_fifo_pkg;

    localparam int unsigned DEPTH     = 4096;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned BUF_DEPTH = 3;

    typedef enum logic [1:0] {GNT_IDLE, GNT_WR, GNT_RD} grant_e;
    typedef enum logic       {PRIO_WR, PRIO_RD}         prio_e;

endpackage

// File: rtl/fifo_out_buf.sv
// Three-entry, 1-bit prefetch buffer holding bits already read out of the RAM.
module fifo_out_buf
    import ramb4_fifo_pkg::*;
(
    input  logic       clk_int,
    input  logic       rst_n,
    input  logic       push,
    input  logic       push_data,
    input  logic       pop,
    output logic       pop_data,
    output logic [1:0] count,
    output logic       valid
);

    logic [BUF_DEPTH-1:0] slots;
    logic [1:0]           wr_idx;
    logic                 pop_eff;

    assign valid    = (count != '0);
    assign pop_data = slots[0];
    assign pop_eff  = pop && valid;

    // Head lives in slot 0; on a simultaneous pop the new bit lands one slot lower.
    always_comb begin
        wr_idx = count;
        if (pop_eff) begin
            wr_idx = count - 2'd1;
        end
    end

    always_ff @(posedge clk_int) begin
        if (!rst_n) begin
            count <= '0;
            slots <= '0;
        end else begin
            if (pop_eff) begin
                slots <= {1'b0, slots[BUF_DEPTH-1:1]};
            end
            if (push && (wr_idx < 2'(BUF_DEPTH))) begin
                slots[wr_idx] <= push_data;
            end
            count <= count + {1'b0, push} - {1'b0, pop_eff};
        end
    end

endmodule

// File: rtl/ramb4_s1_fifo_ctrl.sv
// Single-port RAMB4_S1 FIFO controller: write/read arbitration, pointers and prefetch.
// Define FIFO_CTRL_LEVEL_EN to expose the LEVEL occupancy port.
module ramb4_s1_fifo_ctrl
    import ramb4_fifo_pkg::grant_e, ramb4_fifo_pkg::prio_e,
           ramb4_fifo_pkg::GNT_IDLE, ramb4_fifo_pkg::GNT_WR, ramb4_fifo_pkg::GNT_RD,
           ramb4_fifo_pkg::PRIO_WR, ramb4_fifo_pkg::PRIO_RD;
#(
    parameter int unsigned DEPTH  = ramb4_fifo_pkg::DEPTH,
    parameter int unsigned ADDR_W = ramb4_fifo_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WR_VALID,
    input  logic              WR_DATA,
    output logic              WR_READY,
    output logic              RD_VALID,
    output logic              RD_DATA,
    input  logic              RD_READY,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_DI,
    output logic              RAM_WE,
    output logic              RAM_EN,
    output logic              RAM_RST,
    input  logic              RAM_DO
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_W:0]   LEVEL
`endif
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_count;
    prio_e             prio;
    logic              inflight;
    logic [1:0]        buf_count;
    logic              buf_valid;
    logic              buf_data;
    logic              full;
    logic              want_rd;
    logic              pop;
    grant_e            gnt;

    assign full    = (mem_count == DEPTH_C);
    assign want_rd = (mem_count != '0) && (({1'b0, buf_count} + {2'b00, inflight}) < 3'd3);

    assign RAM_DI   = WR_DATA;
    assign RAM_RST  = ~RST_N;
    assign WR_READY = RST_N && !full && !(want_rd && (prio == PRIO_RD));
    assign RD_VALID = RST_N && buf_valid;
    assign RD_DATA  = buf_data;
    assign pop      = RD_VALID && RD_READY;

    always_comb begin
        gnt      = GNT_IDLE;
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = rd_ptr;
        if (RST_N) begin
            if (want_rd && ((prio == PRIO_RD) || !WR_VALID || full)) begin
                gnt = GNT_RD;
            end else if (WR_VALID && !full) begin
                gnt = GNT_WR;
            end
        end
        unique case (gnt)
            GNT_WR: begin
                RAM_EN   = 1'b1;
                RAM_WE   = 1'b1;
                RAM_ADDR = wr_ptr;
            end
            GNT_RD: begin
                RAM_EN = 1'b1;
            end
            default: ;
        endcase
    end

    // inflight marks a read issued on the previous edge whose data is on RAM_DO now.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            prio      <= PRIO_WR;
            inflight  <= 1'b0;
        end else begin
            unique case (gnt)
                GNT_WR: begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    mem_count <= mem_count + 1'b1;
                    prio      <= PRIO_RD;
                    inflight  <= 1'b0;
                end
                GNT_RD: begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    mem_count <= mem_count - 1'b1;
                    prio      <= PRIO_WR;
                    inflight  <= 1'b1;
                end
                default: begin
                    inflight <= 1'b0;
                end
            endcase
        end
    end

    fifo_out_buf u_out_buf (
        .clk_int   (CLK),
        .rst_n     (RST_N),
        .push      (inflight),
        .push_data (RAM_DO),
        .pop       (pop),
        .pop_data  (buf_data),
        .count     (buf_count),
        .valid     (buf_valid)
    );

`ifdef FIFO_CTRL_LEVEL_EN
    assign LEVEL = mem_count + (ADDR_W + 1)'(inflight) + (ADDR_W + 1)'(buf_count);
`endif

endmodule
